// File: rtl/quad_index_counter.sv
// Quadrature decoder: synchronised A/B/Z, 4x position count, index latch, hold-able snapshot.
// Define QUAD_FILTER_EN to insert the FILT-cycle glitch filter after the synchronisers.
module quad_index_counter #(
  parameter int QW   = 14,
  parameter int FILT = 3
) (
  input  logic          clk,
  input  logic          nRESET,
  input  logic          a,
  input  logic          b,
  input  logic          z,
  input  logic          hold,
  input  logic          idx_clr,
  output logic [2*QW:0] quad,
  output logic          qr,
  output logic          err
);

  if (FILT < 1) begin : g_filt_check
    $error("quad_index_counter: FILT must be at least 1");
  end

  logic [2:0] s1_q, s2_q;
  logic [2:0] f;
  logic       ab_idle;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {z, b, a};
      s2_q <= s1_q;
    end
  end

`ifdef QUAD_FILTER_EN
  localparam int CW = $clog2(FILT + 1);

  for (genvar gi = 0; gi < 3; gi++) begin : g_filt
    logic [CW-1:0] cnt_q, cnt_d;
    logic          f_q, f_d;

    // Input must differ from the filtered state for FILT consecutive cycles.
    always_comb begin
      cnt_d = '0;
      f_d   = f_q;
      if (s2_q[gi] != f_q) begin
        if (cnt_q == CW'(FILT - 1)) begin
          f_d = s2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
        cnt_q <= '0;
        f_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        f_q   <= f_d;
      end
    end

    assign f[gi] = f_q;
  end

  assign ab_idle = (g_filt[0].cnt_q == '0) && (g_filt[1].cnt_q == '0);
`else
  assign f       = s2_q;
  assign ab_idle = 1'b1;
`endif

  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  logic [1:0]    ab_cur;
  logic [1:0]    step;
  logic          z_rise;
  logic [1:0]    prev_q, prev_d;
  logic          primed_q, primed_d;
  logic          fz_prev_q;
  logic [QW-1:0] count_q, count_d;
  logic [QW-1:0] index_pos_q, index_pos_d;
  logic          index_seen_q, index_seen_d;
  logic          err_live_q, err_live_d;
  logic          qr_q, qr_d;
  logic [2*QW:0] quad_q, quad_d;
  logic          err_q, err_d;

  assign ab_cur = {f[0], f[1]};
  assign step   = gray_pos(ab_cur) - gray_pos(prev_q);
  assign z_rise = f[2] & ~fz_prev_q;

  always_comb begin
    prev_d       = prev_q;
    primed_d     = primed_q;
    count_d      = count_q;
    index_pos_d  = index_pos_q;
    index_seen_d = index_seen_q;
    err_live_d   = err_live_q;
    qr_d         = 1'b0;

    if (!primed_q) begin
      if (ab_idle) begin
        prev_d   = ab_cur;
        primed_d = 1'b1;
      end
    end else begin
      prev_d = ab_cur;
      case (step)
        2'd1:    count_d = count_q + QW'(1);
        2'd3:    count_d = count_q - QW'(1);
        2'd2:    err_live_d = 1'b1;
        default: ;
      endcase
    end

    // A clear in the same cycle as a Z edge drops the edge.
    if (idx_clr) begin
      index_seen_d = 1'b0;
      err_live_d   = 1'b0;
    end else if (z_rise && !index_seen_q) begin
      index_pos_d  = count_d;
      index_seen_d = 1'b1;
      qr_d         = 1'b1;
    end

    quad_d = hold ? quad_q : {index_seen_q, index_pos_q, count_q};
    err_d  = hold ? err_q  : err_live_q;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      prev_q       <= '0;
      primed_q     <= 1'b0;
      fz_prev_q    <= 1'b0;
      count_q      <= '0;
      index_pos_q  <= '0;
      index_seen_q <= 1'b0;
      err_live_q   <= 1'b0;
      qr_q         <= 1'b0;
      quad_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      primed_q     <= primed_d;
      fz_prev_q    <= f[2];
      count_q      <= count_d;
      index_pos_q  <= index_pos_d;
      index_seen_q <= index_seen_d;
      err_live_q   <= err_live_d;
      qr_q         <= qr_d;
      quad_q       <= quad_d;
      err_q        <= err_d;
    end
  end

  assign quad = quad_q;
  assign qr   = qr_q;
  assign err  = err_q;

endmodule
